// File: rtl/ssp_fifo_pkg.sv
// ssp_fifo_pkg: shared sizing for the SSP Rx and Tx FIFOs.
//   SSP_DATA_WIDTH  default byte width of each entry
//   SSP_FIFO_DEPTH  default log2 of the entry count
//   SSP_PTR_WIDTH   pointer width (depth bits plus one wrap bit)
package ssp_fifo_pkg;
  localparam int SSP_DATA_WIDTH = 8;
  localparam int SSP_FIFO_DEPTH = 2;
  localparam int SSP_PTR_WIDTH  = SSP_FIFO_DEPTH + 1;
  function automatic int ssp_ptr_width(input int depth);
    return depth + 1;
  endfunction
endpackage

// File: rtl/ssp_tx_fifo_if.sv
// ssp_tx_fifo_if: APB push side and serializer pop side of the SSP Tx FIFO.
//   master: drives PSEL/PWRITE/PWDATA/TX_READY, observes data and flags
//   slave : the FIFO, drives TxDATA/TX_VALID/SSPTXINTR/EMPTY/LEVEL
//   TX_OVERRUN exists only when SSP_TX_OVERRUN_EN is defined
interface ssp_tx_fifo_if
  import ssp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = SSP_DATA_WIDTH,
  parameter int FIFO_DEPTH = SSP_FIFO_DEPTH
) ();
  logic                  PSEL;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  TX_READY;
  logic [DATA_WIDTH-1:0] TxDATA;
  logic                  TX_VALID;
  logic                  SSPTXINTR;
  logic                  EMPTY;
  logic [FIFO_DEPTH:0]   LEVEL;
`ifdef SSP_TX_OVERRUN_EN
  logic                  TX_OVERRUN;
  modport master (output PSEL, PWRITE, PWDATA, TX_READY,
                  input TxDATA, TX_VALID, SSPTXINTR, EMPTY, LEVEL, TX_OVERRUN);
  modport slave  (input PSEL, PWRITE, PWDATA, TX_READY,
                  output TxDATA, TX_VALID, SSPTXINTR, EMPTY, LEVEL, TX_OVERRUN);
`else
  modport master (output PSEL, PWRITE, PWDATA, TX_READY,
                  input TxDATA, TX_VALID, SSPTXINTR, EMPTY, LEVEL);
  modport slave  (input PSEL, PWRITE, PWDATA, TX_READY,
                  output TxDATA, TX_VALID, SSPTXINTR, EMPTY, LEVEL);
`endif
endinterface

// File: rtl/ssp_fifo_mem.sv
// ssp_fifo_mem: 2**FIFO_DEPTH x DATA_WIDTH register array, one write port, async read.
//   clk      write clock (rising edge)
//   we_i     write enable
//   waddr_i  write address, wdata_i write data
//   raddr_i  read address,  rdata_o combinational read data
module ssp_fifo_mem
  import ssp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = SSP_DATA_WIDTH,
  parameter int FIFO_DEPTH = SSP_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [FIFO_DEPTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [FIFO_DEPTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [2**FIFO_DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/ssp_tx_fifo.sv
// ssp_tx_fifo: SSP transmit FIFO, APB pushes bytes, serializer pops with valid/ready.
//   PCLK   clock, all state on the rising edge
//   CLEAR  asynchronous active-high reset (pointers and flags; memory is kept)
//   bus    ssp_tx_fifo_if.slave: PSEL/PWRITE/PWDATA push, TX_READY pop,
//          TxDATA fall-through head, TX_VALID/EMPTY/SSPTXINTR/LEVEL status
//   Define SSP_TX_OVERRUN_EN to add the sticky TX_OVERRUN flag for dropped pushes.
module ssp_tx_fifo
  import ssp_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = SSP_FIFO_DEPTH,
  parameter int DATA_WIDTH = SSP_DATA_WIDTH
) (
  input logic          PCLK,
  input logic          CLEAR,
  ssp_tx_fifo_if.slave bus
);
  localparam int PW = ssp_ptr_width(FIFO_DEPTH);
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          full, empty, push, pop, wr_req;
  // Full when the slot indices meet but the writer has lapped the reader once.
  assign full     = (wr_ptr_q[FIFO_DEPTH-1:0] == rd_ptr_q[FIFO_DEPTH-1:0]) &&
                    (wr_ptr_q[FIFO_DEPTH] != rd_ptr_q[FIFO_DEPTH]);
  assign empty    = wr_ptr_q == rd_ptr_q;
  assign wr_req   = bus.PSEL & bus.PWRITE;
  assign push     = wr_req & ~full;
  assign pop      = ~empty & bus.TX_READY;
  assign wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
  assign rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
  always_ff @(posedge PCLK or posedge CLEAR)
    if (CLEAR) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  assign bus.EMPTY     = empty;
  assign bus.TX_VALID  = ~empty;
  assign bus.SSPTXINTR = full;
  assign bus.LEVEL     = wr_ptr_q - rd_ptr_q;
`ifdef SSP_TX_OVERRUN_EN
  logic overrun_q, overrun_d;
  assign overrun_d = overrun_q | (wr_req & full);
  always_ff @(posedge PCLK or posedge CLEAR)
    if (CLEAR) overrun_q <= 1'b0;
    else overrun_q <= overrun_d;
  assign bus.TX_OVERRUN = overrun_q;
`endif
  ssp_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_mem (
    .clk    (PCLK),
    .we_i   (push),
    .waddr_i(wr_ptr_q[FIFO_DEPTH-1:0]),
    .wdata_i(bus.PWDATA),
    .raddr_i(rd_ptr_q[FIFO_DEPTH-1:0]),
    .rdata_o(bus.TxDATA)
  );
endmodule

// File: tb/tb_ssp_tx_fifo.sv
// tb_ssp_tx_fifo: directed and random checks of ssp_tx_fifo against a queue model.
module tb_ssp_tx_fifo;
  import ssp_fifo_pkg::*;
  logic PCLK = 1'b0;
  logic CLEAR = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] q[$];
  bit   ovr = 1'b0;
  ssp_tx_fifo_if bus ();
  ssp_tx_fifo dut (.PCLK(PCLK), .CLEAR(CLEAR), .bus(bus));
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_level"}, 32'(bus.LEVEL), 32'(q.size()));
    check({tag, "_empty"}, 32'(bus.EMPTY), 32'(q.size() == 0));
    check({tag, "_valid"}, 32'(bus.TX_VALID), 32'(q.size() != 0));
    check({tag, "_full"}, 32'(bus.SSPTXINTR), 32'(q.size() == 4));
    if (q.size() != 0) check({tag, "_txdata"}, 32'(bus.TxDATA), 32'(q[0]));
`ifdef SSP_TX_OVERRUN_EN
    check({tag, "_ovr"}, 32'(bus.TX_OVERRUN), 32'(ovr));
`endif
  endtask

  // One clock: the model applies the FIFO rules to its pre-edge occupancy.
  task automatic step(input string tag, input bit sel, input bit wr, input logic [7:0] d, input bit rdy);
    bit f, e;
    bus.PSEL = sel;
    bus.PWRITE = wr;
    bus.PWDATA = d;
    bus.TX_READY = rdy;
    @(posedge PCLK);
    f = q.size() == 4;
    e = q.size() == 0;
    if (rdy && !e) void'(q.pop_front());
    if (sel && wr && !f) q.push_back(d);
    if (sel && wr && f) ovr = 1'b1;
    #1 check_state(tag);
  endtask

  initial begin
    bus.PSEL = 0; bus.PWRITE = 0; bus.PWDATA = '0; bus.TX_READY = 0;
    repeat (2) @(posedge PCLK);
    #1 CLEAR = 1'b0;
    check_state("reset");
    step("idle_ready", 0, 0, 8'h00, 1);
    step("read_ignored", 1, 0, 8'h99, 0);
    for (int i = 0; i < 4; i++) step("fill", 1, 1, 8'hA1 + 8'(i), 0);
    check("full_flag", 32'(bus.SSPTXINTR), 32'd1);
    step("drop", 1, 1, 8'hFF, 0);
    check("drop_level", 32'(bus.LEVEL), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("drain_order", 32'(bus.TxDATA), 32'(8'hA1 + 8'(i)));
      step("drain", 0, 0, 8'h00, 1);
    end
    check("drained_empty", 32'(bus.EMPTY), 32'd1);
    for (int i = 0; i < 6; i++) step("wrap", 1, 1, 8'h10 + 8'(i), i > 0);
    step("wrap_tail", 0, 0, 8'h00, 1);
    for (int i = 0; i < 4; i++) step("refill", 1, 1, 8'h20 + 8'(i), 0);
    step("full_push_pop", 1, 1, 8'h55, 1);
    check("fpp_level", 32'(bus.LEVEL), 32'd3);
    step("to_two", 0, 0, 8'h00, 1);
    step("two_push_pop", 1, 1, 8'h66, 1);
    check("tpp_level", 32'(bus.LEVEL), 32'd2);
    step("out1", 0, 0, 8'h00, 1);
    check("see_66", 32'(bus.TxDATA), 32'h66);
    step("out2", 0, 0, 8'h00, 1);
    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom), 1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom));
    while (q.size() != 0) step("flush", 0, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) step("pre_clr", 1, 1, 8'h30 + 8'(i), 0);
    step("to_three", 0, 0, 8'h00, 1);
    check("pre_clr_level", 32'(bus.LEVEL), 32'd3);
    #2 CLEAR = 1'b1;
    q.delete();
    ovr = 1'b0;
    #1 check_state("async_clr");
    @(negedge PCLK);
    CLEAR = 1'b0;
    step("post_clr", 1, 1, 8'h77, 0);
    check("post_clr_77", 32'(bus.TxDATA), 32'h77);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
